// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : alu_multicycle
// Purpose  : Execute-stage ALU. Add/sub/compare/logic/buffer ops complete in
//            one cycle; shifts use an iterative 1-bit-per-cycle shifter.
//            Valid/ready handshake toward issue, Done pulse plus held result
//            toward writeback.
// Ports    : MALU_CLOCK_50          - clock, rising edge
//            MALU_RESET_InLow       - synchronous reset, active-low
//            MALU_Valid_In          - request valid
//            MALU_Ready_Out         - request can be accepted this cycle
//            MALU_AluControl_InBUS  - 4-bit operation code
//            MALU_OperandA_InBUS    - operand A
//            MALU_OperandB_InBUS    - operand B (shift amount in low bits)
//            MALU_Result_OutBUS     - registered result, held until next completion
//            MALU_Zero_Out          - registered, result == 0
//            MALU_Done_Out          - one-cycle completion pulse
//            MALU_IllegalOp_Out     - one-cycle pulse with Done for codes 12-15
// Revision : 1.0 - initial release
// ============================================================================
module alu_multicycle #(
  parameter int DATAWIDTH   = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                 MALU_CLOCK_50,
  input  logic                 MALU_RESET_InLow,
  input  logic                 MALU_Valid_In,
  output logic                 MALU_Ready_Out,
  input  logic [3:0]           MALU_AluControl_InBUS,
  input  logic [DATAWIDTH-1:0] MALU_OperandA_InBUS,
  input  logic [DATAWIDTH-1:0] MALU_OperandB_InBUS,
  output logic [DATAWIDTH-1:0] MALU_Result_OutBUS,
  output logic                 MALU_Zero_Out,
  output logic                 MALU_Done_Out,
  output logic                 MALU_IllegalOp_Out
);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_SHIFT = 1'b1;

  localparam logic [1:0] c_KIND_SLL = 2'd0;
  localparam logic [1:0] c_KIND_SRL = 2'd1;
  localparam logic [1:0] c_KIND_SRA = 2'd2;

  localparam logic [3:0] c_OP_ADD   = 4'd0;
  localparam logic [3:0] c_OP_SUB   = 4'd1;
  localparam logic [3:0] c_OP_SLL   = 4'd2;
  localparam logic [3:0] c_OP_SLT   = 4'd3;
  localparam logic [3:0] c_OP_SLTU  = 4'd4;
  localparam logic [3:0] c_OP_XOR   = 4'd5;
  localparam logic [3:0] c_OP_SRL   = 4'd6;
  localparam logic [3:0] c_OP_SRA   = 4'd7;
  localparam logic [3:0] c_OP_OR    = 4'd8;
  localparam logic [3:0] c_OP_AND   = 4'd9;
  localparam logic [3:0] c_OP_BUFFB = 4'd10;
  localparam logic [3:0] c_OP_BUFFA = 4'd11;

  localparam logic [SHAMT_WIDTH-1:0] c_CNT_ONE = {{(SHAMT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATAWIDTH-1:0]   c_ZERO    = '0;

  logic [0:0]             state_q,   state_d;
  logic [DATAWIDTH-1:0]   acc_q,     acc_d;
  logic [SHAMT_WIDTH-1:0] cnt_q,     cnt_d;
  logic [1:0]             kind_q,    kind_d;
  logic [DATAWIDTH-1:0]   result_q,  result_d;
  logic                   zero_q,    zero_d;
  logic                   done_q,    done_d;
  logic                   illegal_q, illegal_d;

  logic                   w_accept;
  logic                   w_is_shift;
  logic [DATAWIDTH-1:0]   w_alu_res;
  logic                   w_alu_illegal;
  logic [DATAWIDTH-1:0]   w_acc_step;

  assign MALU_Ready_Out = (state_q == c_ST_IDLE);
  assign w_accept       = MALU_Valid_In && MALU_Ready_Out;
  assign w_is_shift     = (MALU_AluControl_InBUS == c_OP_SLL) ||
                          (MALU_AluControl_InBUS == c_OP_SRL) ||
                          (MALU_AluControl_InBUS == c_OP_SRA);

  // Single-cycle datapath; shift codes never reach the result from here.
  always_comb begin
    w_alu_res     = c_ZERO;
    w_alu_illegal = 1'b0;
    case (MALU_AluControl_InBUS)
      c_OP_ADD:   w_alu_res = MALU_OperandA_InBUS + MALU_OperandB_InBUS;
      c_OP_SUB:   w_alu_res = MALU_OperandA_InBUS - MALU_OperandB_InBUS;
      c_OP_SLT:   w_alu_res = {{(DATAWIDTH-1){1'b0}},
                               ($signed(MALU_OperandA_InBUS) < $signed(MALU_OperandB_InBUS))};
      c_OP_SLTU:  w_alu_res = {{(DATAWIDTH-1){1'b0}},
                               (MALU_OperandA_InBUS < MALU_OperandB_InBUS)};
      c_OP_XOR:   w_alu_res = MALU_OperandA_InBUS ^ MALU_OperandB_InBUS;
      c_OP_OR:    w_alu_res = MALU_OperandA_InBUS | MALU_OperandB_InBUS;
      c_OP_AND:   w_alu_res = MALU_OperandA_InBUS & MALU_OperandB_InBUS;
      c_OP_BUFFB: w_alu_res = MALU_OperandB_InBUS;
      c_OP_BUFFA: w_alu_res = MALU_OperandA_InBUS;
      c_OP_SLL, c_OP_SRL, c_OP_SRA: w_alu_res = c_ZERO;
      default:    w_alu_illegal = 1'b1;
    endcase
  end

  // One bit position per cycle; SRA replicates the sign bit.
  always_comb begin
    w_acc_step = acc_q;
    case (kind_q)
      c_KIND_SLL: w_acc_step = {acc_q[DATAWIDTH-2:0], 1'b0};
      c_KIND_SRL: w_acc_step = {1'b0, acc_q[DATAWIDTH-1:1]};
      c_KIND_SRA: w_acc_step = {acc_q[DATAWIDTH-1], acc_q[DATAWIDTH-1:1]};
      default:    w_acc_step = acc_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    result_d  = result_q;
    zero_d    = zero_q;
    done_d    = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      c_ST_IDLE: begin
        if (w_accept) begin
          if (w_is_shift) begin
            acc_d   = MALU_OperandA_InBUS;
            cnt_d   = MALU_OperandB_InBUS[SHAMT_WIDTH-1:0];
            kind_d  = (MALU_AluControl_InBUS == c_OP_SLL) ? c_KIND_SLL :
                      (MALU_AluControl_InBUS == c_OP_SRL) ? c_KIND_SRL : c_KIND_SRA;
            state_d = c_ST_SHIFT;
          end else begin
            result_d  = w_alu_res;
            zero_d    = (w_alu_res == c_ZERO);
            done_d    = 1'b1;
            illegal_d = w_alu_illegal;
          end
        end
      end
      c_ST_SHIFT: begin
        if (cnt_q != '0) begin
          acc_d = w_acc_step;
          cnt_d = cnt_q - c_CNT_ONE;
        end else begin
          // Count exhausted: the accumulator already holds the final value.
          result_d = acc_q;
          zero_d   = (acc_q == c_ZERO);
          done_d   = 1'b1;
          state_d  = c_ST_IDLE;
        end
      end
      default: state_d = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge MALU_CLOCK_50) begin
    if (!MALU_RESET_InLow) begin
      state_q   <= c_ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      kind_q    <= c_KIND_SLL;
      result_q  <= '0;
      zero_q    <= 1'b1;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
    end
  end

  assign MALU_Result_OutBUS = result_q;
  assign MALU_Zero_Out      = zero_q;
  assign MALU_Done_Out      = done_q;
  assign MALU_IllegalOp_Out = illegal_q;

endmodule
`default_nettype wire
